// File: rtl/sd_card_cmd_if.sv
// CMD-line and response-request bundle for the SD card command engine.
// The slave side is the card logic; the master side is the host/user side.
interface sd_card_cmd_if;
  logic         cmd_pin_in;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         crc_err;
  logic         resp_start;
  logic         resp_long;
  logic [5:0]   resp_index;
  logic [31:0]  resp_arg;
  logic [119:0] resp_payload;
  logic         busy;

  modport slave (
    input  cmd_pin_in, resp_start, resp_long, resp_index, resp_arg, resp_payload,
    output cmd_pin_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, busy
  );

  modport master (
    output cmd_pin_in, resp_start, resp_long, resp_index, resp_arg, resp_payload,
    input  cmd_pin_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, crc_err, busy
  );
endinterface

// File: rtl/sd_card_cmd.sv
// SD card CMD-line engine: receives 48-bit host commands with CRC7 checking
// and transmits 48-bit or 136-bit (R2) responses after an NCR idle gap.
module sd_card_cmd #(
  parameter int unsigned NCR = 2  // idle bit periods before a response, 2..64
) (
  input logic         clock,
  input logic         reset,
  sd_card_cmd_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    WAIT_RESP,
    NCR_WAIT,
    TX
  } state_t;

  state_t       state;
  logic [7:0]   bit_cnt;   // RX: index of last bit taken; NCR_WAIT: gap count; TX: index on the line
  logic [6:0]   crc;
  logic [45:0]  rx_sr;     // command bits 46..1 once the end bit arrives
  logic [135:0] tx_sr;     // remaining response content, MSB goes out next
  logic         tx_long;

  logic         pin_out_r;
  logic         oe_r;
  logic         valid_r;
  logic         err_r;
  logic         busy_r;
  logic [5:0]   index_r;
  logic [31:0]  arg_r;

  // CRC7 x^7 + x^3 + 1, one bit per step.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  logic [46:0] rx_word;
  logic [7:0]  rx_pos;
  logic        rx_good;
  logic [7:0]  tx_next;
  logic [7:0]  tx_last;
  logic [7:0]  tx_crc_first;
  logic        tx_crc_take;

  // Decode of the frame being received and of the next response bit position.
  always_comb begin
    rx_word      = {rx_sr, bus.cmd_pin_in};
    rx_pos       = bit_cnt + 8'd1;
    rx_good      = rx_word[46] && (rx_word[7:1] == crc) && rx_word[0];
    tx_next      = bit_cnt + 8'd1;
    tx_last      = tx_long ? 8'd135 : 8'd47;
    tx_crc_first = tx_long ? 8'd128 : 8'd40;
    // R2 CRC covers the payload only, so the 8 header bits are skipped.
    tx_crc_take  = !tx_long || (tx_next >= 8'd8);
  end

  // Command/response sequencer with registered CMD-line and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      crc       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      tx_long   <= 1'b0;
      pin_out_r <= 1'b1;
      oe_r      <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      index_r   <= '0;
      arg_r     <= '0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.cmd_pin_in) begin
            state   <= RX;
            bit_cnt <= '0;
            crc     <= '0;
            rx_sr   <= '0;
          end
        end

        RX: begin
          if (rx_pos < 8'd40) begin
            crc <= crc7_step(crc, bus.cmd_pin_in);
          end
          if (rx_pos == 8'd47) begin
            bit_cnt <= '0;
            if (rx_good) begin
              valid_r <= 1'b1;
              index_r <= rx_word[45:40];
              arg_r   <= rx_word[39:8];
              state   <= WAIT_RESP;
            end else begin
              err_r <= 1'b1;
              state <= IDLE;
            end
          end else begin
            rx_sr   <= rx_word[45:0];
            bit_cnt <= rx_pos;
          end
        end

        WAIT_RESP: begin
          // A new start bit outranks a simultaneous response request.
          if (!bus.cmd_pin_in) begin
            state   <= RX;
            bit_cnt <= '0;
            crc     <= '0;
            rx_sr   <= '0;
          end else if (bus.resp_start) begin
            state   <= NCR_WAIT;
            busy_r  <= 1'b1;
            bit_cnt <= '0;
            crc     <= '0;
            tx_long <= bus.resp_long;
            if (bus.resp_long) begin
              tx_sr <= {2'b00, 6'b111111, bus.resp_payload, 8'h00};
            end else begin
              tx_sr <= {2'b00, bus.resp_index, bus.resp_arg, 96'h0};
            end
          end
        end

        NCR_WAIT: begin
          if (bit_cnt == 8'(NCR - 1)) begin
            state     <= TX;
            bit_cnt   <= '0;
            oe_r      <= 1'b1;
            pin_out_r <= tx_sr[135];
            tx_sr     <= {tx_sr[134:0], 1'b0};
            if (!tx_long) begin
              crc <= crc7_step(crc, tx_sr[135]);
            end
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end

        TX: begin
          if (bit_cnt == tx_last) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            oe_r      <= 1'b0;
            pin_out_r <= 1'b1;
            busy_r    <= 1'b0;
          end else begin
            bit_cnt <= tx_next;
            // Content and CRC are produced serially: data bits feed the CRC
            // as they leave, then the CRC register itself is shifted out.
            if (tx_next < tx_crc_first) begin
              pin_out_r <= tx_sr[135];
              tx_sr     <= {tx_sr[134:0], 1'b0};
              if (tx_crc_take) begin
                crc <= crc7_step(crc, tx_sr[135]);
              end
            end else if (tx_next < tx_last) begin
              pin_out_r <= crc[6];
              crc       <= {crc[5:0], 1'b0};
            end else begin
              pin_out_r <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          oe_r      <= 1'b0;
          pin_out_r <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_pin_out = pin_out_r;
  assign bus.cmd_oe      = oe_r;
  assign bus.cmd_valid   = valid_r;
  assign bus.crc_err     = err_r;
  assign bus.busy        = busy_r;
  assign bus.cmd_index   = index_r;
  assign bus.cmd_arg     = arg_r;

endmodule

// File: tb/tb_sd_card_cmd.sv
// Directed bench for sd_card_cmd: command reception, CRC rejection,
// short and R2 responses, start-bit/response collision and reset mid-TX.
module tb_sd_card_cmd;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  sd_card_cmd_if bus ();

  sd_card_cmd #(.NCR(2)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a 48-bit frame MSB first; counts pulses seen before the end bit
  // and cycles with cmd_oe high. resp_start is dropped after the first edge.
  task automatic send_cmd(input logic [47:0] w, output int n_early, output int n_oe);
    n_early = 0;
    n_oe    = 0;
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_pin_in = w[i];
      step();
      bus.resp_start = 1'b0;
      if (i != 0 && (bus.cmd_valid || bus.crc_err)) n_early++;
      if (bus.cmd_oe) n_oe++;
    end
    bus.cmd_pin_in = 1'b1;
  endtask

  // Wait (bounded) for cmd_oe after the resp_start edge, counting idle cycles.
  task automatic wait_tx(output int idle);
    idle = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      bus.resp_start = 1'b0;
      if (bus.cmd_oe) break;
      idle++;
    end
  endtask

  // Collect n response bits; cmd_pin_in is toggled to show it is ignored.
  task automatic capture(input int n, output logic [135:0] bits,
                         output int n_oe_low, output int n_busy_low);
    bits       = '0;
    n_oe_low   = 0;
    n_busy_low = 0;
    for (int k = 0; k < n; k++) begin
      bits = {bits[134:0], bus.cmd_pin_out};
      if (!bus.cmd_oe) n_oe_low++;
      if (!bus.busy) n_busy_low++;
      bus.cmd_pin_in = (k < n - 4) ? 1'(k & 1) : 1'b1;
      step();
    end
    bus.cmd_pin_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (bus.cmd_oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", bus.cmd_oe); else passed++;
    total++; if (bus.cmd_pin_out !== 1'b1) $display("FAIL reset_pin_out got=%b exp=1", bus.cmd_pin_out); else passed++;
    total++; if (bus.cmd_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.cmd_valid); else passed++;
    total++; if (bus.crc_err !== 1'b0) $display("FAIL reset_crc_err got=%b exp=0", bus.crc_err); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.cmd_index !== 6'd0) $display("FAIL reset_index got=%0d exp=0", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'd0) $display("FAIL reset_arg got=%h exp=0", bus.cmd_arg); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_cmd();
    int early, noe;
    send_cmd(48'h40_00000000_95, early, noe);
    total++; if (early !== 0) $display("FAIL cmd0_early_pulse got=%0d exp=0", early); else passed++;
    total++; if (noe !== 0) $display("FAIL cmd0_oe_during_rx got=%0d exp=0", noe); else passed++;
    total++; if (bus.cmd_valid !== 1'b1) $display("FAIL cmd0_valid got=%b exp=1", bus.cmd_valid); else passed++;
    total++; if (bus.crc_err !== 1'b0) $display("FAIL cmd0_crc_err got=%b exp=0", bus.crc_err); else passed++;
    total++; if (bus.cmd_index !== 6'd0) $display("FAIL cmd0_index got=%0d exp=0", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'd0) $display("FAIL cmd0_arg got=%h exp=0", bus.cmd_arg); else passed++;
    step();
    total++; if (bus.cmd_valid !== 1'b0) $display("FAIL cmd0_valid_width got=%b exp=0", bus.cmd_valid); else passed++;
  endtask

  task automatic test_short_resp();
    int early, noe, idle, oe_low, busy_low;
    logic [135:0] bits;
    send_cmd(48'h48_000001AA_87, early, noe);
    total++; if (bus.cmd_valid !== 1'b1) $display("FAIL cmd8_valid got=%b exp=1", bus.cmd_valid); else passed++;
    total++; if (bus.cmd_index !== 6'd8) $display("FAIL cmd8_index got=%0d exp=8", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'h1AA) $display("FAIL cmd8_arg got=%h exp=000001aa", bus.cmd_arg); else passed++;
    bus.resp_start   = 1'b1;
    bus.resp_long    = 1'b0;
    bus.resp_index   = 6'd8;
    bus.resp_arg     = 32'h1AA;
    bus.resp_payload = '1;
    wait_tx(idle);
    total++; if (idle !== 2) $display("FAIL r7_ncr_idle got=%0d exp=2", idle); else passed++;
    capture(48, bits, oe_low, busy_low);
    total++; if (bits[47:0] !== 48'h08_000001AA_13) $display("FAIL r7_frame got=%h exp=08000001aa13", bits[47:0]); else passed++;
    total++; if (oe_low !== 0) $display("FAIL r7_oe_low_cycles got=%0d exp=0", oe_low); else passed++;
    total++; if (busy_low !== 0) $display("FAIL r7_busy_low_cycles got=%0d exp=0", busy_low); else passed++;
    total++; if (bus.cmd_oe !== 1'b0) $display("FAIL r7_oe_after got=%b exp=0", bus.cmd_oe); else passed++;
    total++; if (bus.cmd_pin_out !== 1'b1) $display("FAIL r7_pin_after got=%b exp=1", bus.cmd_pin_out); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL r7_busy_after got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_bad_crc();
    int early, noe, act;
    send_cmd(48'h51_00000000_57, early, noe);
    total++; if (early !== 0) $display("FAIL bad_early_pulse got=%0d exp=0", early); else passed++;
    total++; if (bus.crc_err !== 1'b1) $display("FAIL bad_crc_err got=%b exp=1", bus.crc_err); else passed++;
    total++; if (bus.cmd_valid !== 1'b0) $display("FAIL bad_valid got=%b exp=0", bus.cmd_valid); else passed++;
    total++; if (bus.cmd_index !== 6'd8) $display("FAIL bad_index_held got=%0d exp=8", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'h1AA) $display("FAIL bad_arg_held got=%h exp=000001aa", bus.cmd_arg); else passed++;
    step();
    total++; if (bus.crc_err !== 1'b0) $display("FAIL bad_crc_err_width got=%b exp=0", bus.crc_err); else passed++;
    // Back in IDLE, so a response request must be ignored.
    act = 0;
    bus.resp_start = 1'b1;
    bus.resp_long  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.cmd_oe || bus.busy) act++;
    end
    bus.resp_start = 1'b0;
    total++; if (act !== 0) $display("FAIL bad_resp_ignored got=%0d exp=0", act); else passed++;
  endtask

  task automatic test_long_resp();
    int early, noe, idle, oe_low, busy_low;
    logic [135:0] bits;
    logic [135:0] expv;
    send_cmd(48'h40_00000000_95, early, noe);
    total++; if (bus.cmd_valid !== 1'b1) $display("FAIL r2_cmd_valid got=%b exp=1", bus.cmd_valid); else passed++;
    bus.resp_start   = 1'b1;
    bus.resp_long    = 1'b1;
    bus.resp_index   = 6'h15;
    bus.resp_arg     = 32'hDEADBEEF;
    bus.resp_payload = '0;
    wait_tx(idle);
    total++; if (idle !== 2) $display("FAIL r2_ncr_idle got=%0d exp=2", idle); else passed++;
    capture(136, bits, oe_low, busy_low);
    expv = '0;
    expv[133:128] = 6'b111111;
    expv[0] = 1'b1;
    total++; if (bits !== expv) $display("FAIL r2_frame got=%h exp=%h", bits, expv); else passed++;
    total++; if (oe_low !== 0) $display("FAIL r2_oe_low_cycles got=%0d exp=0", oe_low); else passed++;
    total++; if (busy_low !== 0) $display("FAIL r2_busy_low_cycles got=%0d exp=0", busy_low); else passed++;
    total++; if (bus.cmd_oe !== 1'b0) $display("FAIL r2_oe_after got=%b exp=0", bus.cmd_oe); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL r2_busy_after got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_collision();
    int early, noe, act;
    send_cmd(48'h40_00000000_95, early, noe);
    total++; if (bus.cmd_index !== 6'd0) $display("FAIL coll_pre_index got=%0d exp=0", bus.cmd_index); else passed++;
    bus.resp_start = 1'b1;
    bus.resp_long  = 1'b0;
    bus.resp_index = 6'd3;
    send_cmd(48'h51_00000000_55, early, noe);
    total++; if (noe !== 0) $display("FAIL coll_oe_during_rx got=%0d exp=0", noe); else passed++;
    total++; if (bus.cmd_valid !== 1'b1) $display("FAIL coll_valid got=%b exp=1", bus.cmd_valid); else passed++;
    total++; if (bus.cmd_index !== 6'd17) $display("FAIL coll_index got=%0d exp=17", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'd0) $display("FAIL coll_arg got=%h exp=0", bus.cmd_arg); else passed++;
    act = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.cmd_oe || bus.busy) act++;
    end
    total++; if (act !== 0) $display("FAIL coll_no_response got=%0d exp=0", act); else passed++;
  endtask

  task automatic test_reset_mid_tx();
    int idle, oe_low, busy_low;
    logic [135:0] bits;
    bus.resp_start = 1'b1;
    bus.resp_long  = 1'b0;
    bus.resp_index = 6'd8;
    bus.resp_arg   = 32'h1AA;
    wait_tx(idle);
    capture(20, bits, oe_low, busy_low);
    total++; if (bus.cmd_oe !== 1'b1) $display("FAIL rst_tx_active got=%b exp=1", bus.cmd_oe); else passed++;
    rst_n = 1'b0;
    step();
    total++; if (bus.cmd_oe !== 1'b0) $display("FAIL rst_tx_oe got=%b exp=0", bus.cmd_oe); else passed++;
    total++; if (bus.cmd_pin_out !== 1'b1) $display("FAIL rst_tx_pin got=%b exp=1", bus.cmd_pin_out); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_tx_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.cmd_valid !== 1'b0 || bus.crc_err !== 1'b0) $display("FAIL rst_tx_pulses got=%b%b exp=00", bus.cmd_valid, bus.crc_err); else passed++;
    total++; if (bus.cmd_index !== 6'd0) $display("FAIL rst_tx_index got=%0d exp=0", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'd0) $display("FAIL rst_tx_arg got=%h exp=0", bus.cmd_arg); else passed++;
  endtask

  task automatic test_after_reset();
    int early, noe;
    rst_n = 1'b1;
    send_cmd(48'h48_000001AA_87, early, noe);
    total++; if (bus.cmd_valid !== 1'b1) $display("FAIL post_rst_valid got=%b exp=1", bus.cmd_valid); else passed++;
    total++; if (bus.cmd_index !== 6'd8) $display("FAIL post_rst_index got=%0d exp=8", bus.cmd_index); else passed++;
    total++; if (bus.cmd_arg !== 32'h1AA) $display("FAIL post_rst_arg got=%h exp=000001aa", bus.cmd_arg); else passed++;
  endtask

  initial begin
    passed           = 0;
    total            = 0;
    rst_n            = 1'b0;
    bus.cmd_pin_in   = 1'b1;
    bus.resp_start   = 1'b0;
    bus.resp_long    = 1'b0;
    bus.resp_index   = '0;
    bus.resp_arg     = '0;
    bus.resp_payload = '0;
    test_reset();
    test_good_cmd();
    test_short_resp();
    test_bad_crc();
    test_long_resp();
    test_collision();
    test_reset_mid_tx();
    test_after_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sd_card_cmd.md
SD_CARD_CMD -- requirements
Module: sd_card_cmd

Interface
REQ-001 Parameter: NCR, 2, idle bit periods between a received command's end bit and the response start bit (legal 2..64).
REQ-002 The block SHALL have a single clock; reset is synchronous and active-low.
REQ-003 clock  in  1  bit clock; one CMD bit sampled or driven per rising edge.
REQ-004 reset  in  1  synchronous active-low reset.
REQ-005 cmd_pin_in  in  1  CMD line as seen by the card; idle high.
REQ-006 cmd_pin_out  out  1  CMD bit driven by the card.
REQ-007 cmd_oe  out  1  high while the card drives CMD.
REQ-008 cmd_valid  out  1  one-cycle pulse: good command received.
REQ-009 cmd_index  out  6  index of the last good command.
REQ-010 cmd_arg  out  32  argument of the last good command.
REQ-011 crc_err  out  1  one-cycle pulse: command rejected (CRC, transmission bit or end bit).
REQ-012 resp_start  in  1  request to send a response; sampled only in WAIT_RESP.
REQ-013 resp_long  in  1  0 = 48-bit response, 1 = 136-bit R2; sampled with resp_start.
REQ-014 resp_index  in  6  index field for a 48-bit response.
REQ-015 resp_arg  in  32  argument field for a 48-bit response.
REQ-016 resp_payload  in  120  CID/CSD bits [127:8] for R2.
REQ-017 busy  out  1  high in NCR_WAIT and TX.

Function
REQ-018 FSM states SHALL be IDLE, RX, WAIT_RESP, NCR_WAIT, TX.
REQ-019 IDLE: cmd_pin_in = 0 sampled -> RX; that edge counts as bit 47 (start bit).
REQ-020 RX: shift 48 bits MSB first; CRC7 (x^7+x^3+1, init 0) over bits 47..8.
REQ-021 After the end bit: good if bit 46 = 1, received CRC = computed CRC and end bit = 1.
REQ-022 Good command: cmd_index and cmd_arg update and cmd_valid pulses in the cycle after the end-bit edge; FSM -> WAIT_RESP.
REQ-023 Bad command: crc_err pulses in that same cycle; cmd_index and cmd_arg are held; FSM -> IDLE.
REQ-024 WAIT_RESP: resp_start = 1 latches resp_long, resp_index, resp_arg and resp_payload; FSM -> NCR_WAIT.
REQ-025 WAIT_RESP: cmd_pin_in = 0 aborts the pending response and enters RX as a new start bit; on the same edge as resp_start, the new command SHALL win.
REQ-026 NCR_WAIT: cmd_oe = 0 for exactly NCR cycles; FSM -> TX.
REQ-027 TX short (48 bits, MSB first): 0, 0, index[5:0], arg[31:0], CRC7 over the first 40 bits, 1.
REQ-028 TX long (136 bits, MSB first): 0, 0, 111111, payload[119:0], CRC7 over payload only, 1.
REQ-029 TX: cmd_oe = 1 for every bit; cmd_pin_in is ignored; cmd_oe falls the cycle after the end bit; FSM -> IDLE.
REQ-030 resp_start outside WAIT_RESP SHALL be ignored; cmd_pin_out SHALL be 1 whenever cmd_oe = 0.
REQ-031 Bit counter SHALL be 8 bits and hold 0..135 with no wrap; the CRC register clears at each start bit.

Reset
REQ-032 reset = 0 at a rising edge SHALL force:
- FSM to IDLE
- cmd_oe = 0, cmd_pin_out = 1
- cmd_valid = 0, crc_err = 0, busy = 0
- cmd_index = 0, cmd_arg = 0
- counters and CRC cleared
REQ-033 Reset asserted mid-RX or mid-TX SHALL drop cmd_oe at that edge; no partial cmd_valid or crc_err pulse.
REQ-034 After reset releases, the block SHALL be in IDLE and SHALL accept a start bit on the first following edge.

Verification
REQ-035 Good command: drive 0x40_00000000_95 (CMD0) -> cmd_valid pulse 1 cycle, cmd_index = 0, cmd_arg = 0, crc_err = 0.
REQ-036 Short response: drive 0x48_000001AA_87 (CMD8), then resp_start with resp_long = 0, resp_index = 8, resp_arg = 0x1AA -> line idle exactly 2 cycles, then 0x08_000001AA_13 with cmd_oe high for 48 cycles.
REQ-037 Bad CRC: drive 0x51_00000000_57 -> crc_err pulse, no cmd_valid, cmd_index and cmd_arg unchanged, FSM IDLE.
REQ-038 R2 response: resp_long = 1, resp_payload = 0 -> 136 bits 0,0,111111, 120 zeros, CRC 0000000, 1; busy high through the end bit.
REQ-039 Collision: in WAIT_RESP, resp_start and a start bit on the same edge -> no response, new command received (0x51_00000000_55 gives cmd_index = 17).
REQ-040 Reset mid-TX at bit 20 -> cmd_oe = 0 and cmd_pin_out = 1 at that edge, all outputs at reset values.
